// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: drives the register bank write port and both read ports to fill
// consecutive registers starting at BASE_REG with F(0)..F(N-1), one term per cycle.
module fib_seq_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned BASE_REG = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [5:0]        n_terms,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DATA_W-1:0] result,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_dir,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_dir1,
    output logic [ADDR_W-1:0] rf_read_dir2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    // Counter wide enough for both the 6-bit request and the full bank size.
    localparam int unsigned CntW = ((ADDR_W > 6) ? ADDR_W : 6) + 1;
    localparam int unsigned MaxN = (1 << ADDR_W) - BASE_REG;

    typedef enum logic [2:0] {StIdle, StInit0, StInit1, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   n_q, n_d;
    logic [CntW-1:0]   idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [CntW-1:0]   n_clamped;
    logic [CntW-1:0]   wr_pos;
    logic [DATA_W:0]   sum;

    always_comb begin
        n_clamped = (CntW'(n_terms) > CntW'(MaxN)) ? CntW'(MaxN) : CntW'(n_terms);
        wr_pos    = CntW'(BASE_REG) + idx_q;
        sum       = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        result_d   = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d        = n_clamped;
                    overflow_d = 1'b0;
                    result_d   = '0;
                    state_d    = (n_clamped == '0) ? StDone : StInit0;
                end
            end
            StInit0: begin
                result_d = '0;
                state_d  = (n_q == CntW'(1)) ? StDone : StInit1;
            end
            StInit1: begin
                result_d = DATA_W'(1);
                idx_d    = CntW'(2);
                state_d  = (n_q == CntW'(2)) ? StDone : StCalc;
            end
            StCalc: begin
                result_d = sum[DATA_W-1:0];
                // Overflow is sticky for the run; the truncated sum is still stored.
                if (sum[DATA_W]) begin
                    overflow_d = 1'b1;
                end
                idx_d = idx_q + CntW'(1);
                if (idx_q == n_q - CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            n_q        <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            result_q   <= result_d;
        end
    end

    // Port drive decoded from the registered state; only the CALC write data is combinational.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        rf_write_en   = 1'b0;
        rf_write_dir  = '0;
        rf_write_data = '0;
        rf_read_dir1  = '0;
        rf_read_dir2  = '0;
        unique case (state_q)
            StIdle: begin
            end
            StInit0: begin
                busy         = 1'b1;
                rf_write_en  = 1'b1;
                rf_write_dir = ADDR_W'(BASE_REG);
            end
            StInit1: begin
                busy          = 1'b1;
                rf_write_en   = 1'b1;
                rf_write_dir  = ADDR_W'(BASE_REG + 1);
                rf_write_data = DATA_W'(1);
            end
            StCalc: begin
                busy          = 1'b1;
                rf_write_en   = 1'b1;
                rf_write_dir  = ADDR_W'(wr_pos);
                rf_write_data = sum[DATA_W-1:0];
                rf_read_dir1  = ADDR_W'(wr_pos - CntW'(1));
                rf_read_dir2  = ADDR_W'(wr_pos - CntW'(2));
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign overflow = overflow_q;
    assign result   = result_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: a bank model serves the read ports and logs every write; the
// expected series, clamp, overflow and latency come from plain arithmetic on the rules.
module tb_fib_seq_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int BASE = 1;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start;
    logic [5:0]    n_terms;
    logic          busy, done, overflow;
    logic [DW-1:0] result;
    logic          rf_write_en;
    logic [AW-1:0] rf_write_dir, rf_read_dir1, rf_read_dir2;
    logic [DW-1:0] rf_write_data, rf_read_data1, rf_read_data2;

    logic [DW-1:0] bank [NREG];
    logic [AW-1:0] wlog_a [$];
    logic [DW-1:0] wlog_d [$];

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .BASE_REG (BASE)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .start         (start),
        .n_terms       (n_terms),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .result        (result),
        .rf_write_en   (rf_write_en),
        .rf_write_dir  (rf_write_dir),
        .rf_write_data (rf_write_data),
        .rf_read_dir1  (rf_read_dir1),
        .rf_read_dir2  (rf_read_dir2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    assign rf_read_data1 = bank[rf_read_dir1];
    assign rf_read_data2 = bank[rf_read_dir2];

    always @(posedge clk) begin
        if (rf_write_en) begin
            bank[rf_write_dir] <= rf_write_data;
            wlog_a.push_back(rf_write_dir);
            wlog_d.push_back(rf_write_data);
        end
    end

    // ---------------- reference model ----------------
    function automatic int clamp_n(input int n);
        return (n > NREG - BASE) ? NREG - BASE : n;
    endfunction

    function automatic logic [DW-1:0] fib_term(input int k);
        longint m = longint'(1) << DW;
        longint a = 0, b = 1, t;
        if (k == 0) return '0;
        for (int i = 1; i < k; i++) begin
            t = (a + b) % m;
            a = b;
            b = t;
        end
        return DW'(b);
    endfunction

    function automatic bit fib_ovf(input int n);
        longint m = longint'(1) << DW;
        longint a = 0, b = 1, t;
        bit ovf = 1'b0;
        for (int k = 2; k < n; k++) begin
            if (a + b >= m) ovf = 1'b1;
            t = (a + b) % m;
            a = b;
            b = t;
        end
        return ovf;
    endfunction

    function automatic logic [DW-1:0] exp_result(input int nc);
        return (nc == 0) ? '0 : fib_term(nc - 1);
    endfunction

    // Number of write-log entries since wbase that disagree with the expected series.
    function automatic int log_errors(input int wbase, input int nc);
        int errs = 0;
        int got  = wlog_a.size() - wbase;
        if (got != nc) errs++;
        for (int i = 0; i < nc && i < got; i++) begin
            if (wlog_a[wbase + i] !== AW'(BASE + i) || wlog_d[wbase + i] !== fib_term(i))
                errs++;
        end
        return errs;
    endfunction

    // Issue a start, optionally pulse start again in cycle pulse_k, and observe done.
    task automatic run(input int n, input int pulse_k,
                       output int done_k, output int ndone, output int wbase);
        int nc = clamp_n(n);
        wbase   = wlog_a.size();
        n_terms = 6'(n);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n_terms = 6'($urandom);
        done_k  = -1;
        ndone   = 0;
        for (int k = 1; k <= nc + 4; k++) begin
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            start = (k == pulse_k);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst_n  = 1'b0;
        start   = 1'b0;
        n_terms = '0;
        #2;
        ntot++;
        if ({busy, done, overflow, rf_write_en} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, rf_write_en});
        else npass++;
        ntot++;
        if (result !== '0) $display("FAIL reset_result: got %0d want 0", result);
        else npass++;
        ntot++;
        if ({rf_write_dir, rf_write_data, rf_read_dir1, rf_read_dir2} !== '0)
            $display("FAIL reset_rf: got %h want 0",
                     {rf_write_dir, rf_write_data, rf_read_dir1, rf_read_dir2});
        else npass++;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fib10();
        int dk, nd, wb, e;
        run(10, 0, dk, nd, wb);
        e = log_errors(wb, 10);
        ntot++;
        if (e != 0) $display("FAIL fib10_writes: got %0d bad entries want 0", e);
        else npass++;
        ntot++;
        if (wlog_d[wb + 9] !== DW'(34)) $display("FAIL fib10_reg10: got %0d want 34", wlog_d[wb + 9]);
        else npass++;
        ntot++;
        if (result !== exp_result(10)) $display("FAIL fib10_result: got %0d want %0d", result, exp_result(10));
        else npass++;
        ntot++;
        if (dk != 11 || nd != 1) $display("FAIL fib10_done: got k=%0d n=%0d want k=11 n=1", dk, nd);
        else npass++;
        ntot++;
        if (overflow !== 1'b0 || busy !== 1'b0)
            $display("FAIL fib10_idle: got ovf=%b busy=%b want 0 0", overflow, busy);
        else npass++;
    endtask

    task automatic test_small();
        int dk, nd, wb, e;
        for (int n = 0; n <= 2; n++) begin
            run(n, 0, dk, nd, wb);
            e = log_errors(wb, n);
            ntot++;
            if (e != 0) $display("FAIL small%0d_writes: got %0d bad entries want 0", n, e);
            else npass++;
            ntot++;
            if (dk != n + 1 || nd != 1)
                $display("FAIL small%0d_done: got k=%0d n=%0d want k=%0d n=1", n, dk, nd, n + 1);
            else npass++;
            ntot++;
            if (result !== DW'(n == 2 ? 1 : 0))
                $display("FAIL small%0d_result: got %0d want %0d", n, result, (n == 2 ? 1 : 0));
            else npass++;
        end
    endtask

    task automatic test_clamp();
        int dk, nd, wb, e, z;
        run(40, 0, dk, nd, wb);
        e = log_errors(wb, 31);
        z = 0;
        for (int i = wb; i < wlog_a.size(); i++) if (wlog_a[i] == '0) z++;
        ntot++;
        if (e != 0) $display("FAIL clamp_writes: got %0d bad entries want 0", e);
        else npass++;
        ntot++;
        if (z != 0) $display("FAIL clamp_addr0: got %0d writes to reg 0 want 0", z);
        else npass++;
        ntot++;
        if (result !== exp_result(31)) $display("FAIL clamp_result: got %0d want %0d", result, exp_result(31));
        else npass++;
        ntot++;
        if (dk != 32 || nd != 1) $display("FAIL clamp_done: got k=%0d n=%0d want k=32 n=1", dk, nd);
        else npass++;
    endtask

    task automatic test_overflow();
        int dk, nd, wb;
        run(26, 0, dk, nd, wb);
        ntot++;
        if (wlog_d[wb + 24] !== DW'(46368) || wlog_d[wb + 25] !== DW'(9489))
            $display("FAIL ovf_terms: got %0d %0d want 46368 9489", wlog_d[wb + 24], wlog_d[wb + 25]);
        else npass++;
        ntot++;
        if (result !== DW'(9489)) $display("FAIL ovf_result: got %0d want 9489", result);
        else npass++;
        repeat (3) @(posedge clk);
        #1;
        ntot++;
        if (overflow !== fib_ovf(26)) $display("FAIL ovf_sticky: got %b want %b", overflow, fib_ovf(26));
        else npass++;
        run(3, 0, dk, nd, wb);
        ntot++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
        else npass++;
    endtask

    task automatic test_ignore_start();
        int dk, nd, wb, e;
        // cycle 6 is CALC with idx=5
        run(10, 6, dk, nd, wb);
        e = log_errors(wb, 10);
        ntot++;
        if (e != 0 || dk != 11 || nd != 1)
            $display("FAIL ign_busy: got err=%0d k=%0d n=%0d want 0 11 1", e, dk, nd);
        else npass++;
        // cycle 6 is the DONE cycle of a 5-term run
        run(5, 6, dk, nd, wb);
        e = log_errors(wb, 5);
        ntot++;
        if (e != 0 || nd != 1 || busy !== 1'b0)
            $display("FAIL ign_done: got err=%0d n=%0d busy=%b want 0 1 0", e, nd, busy);
        else npass++;
    endtask

    task automatic test_reset_mid();
        int dk, nd, wb, e;
        n_terms = 6'd10;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        ntot++;
        if (busy !== 1'b1 || rf_write_dir !== AW'(BASE + 6))
            $display("FAIL rstmid_pre: got busy=%b dir=%0d want 1 %0d", busy, rf_write_dir, BASE + 6);
        else npass++;
        arst_n = 1'b0;
        #1;
        ntot++;
        if ({busy, rf_write_en, done} !== 3'b0 || result !== '0)
            $display("FAIL rstmid_drop: got %b res=%0d want 000 res=0", {busy, rf_write_en, done}, result);
        else npass++;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        run(4, 0, dk, nd, wb);
        e = log_errors(wb, 4);
        ntot++;
        if (e != 0 || result !== DW'(2) || dk != 5)
            $display("FAIL rstmid_rerun: got err=%0d res=%0d k=%0d want 0 2 5", e, result, dk);
        else npass++;
    endtask

    task automatic test_random();
        int dk, nd, wb, e, n, nc, pk;
        for (int it = 0; it < 10; it++) begin
            n  = int'($urandom_range(0, 63));
            nc = clamp_n(n);
            pk = int'($urandom_range(0, nc + 1));
            run(n, pk, dk, nd, wb);
            e = log_errors(wb, nc);
            ntot++;
            if (e != 0 || dk != nc + 1 || nd != 1)
                $display("FAIL rand%0d_seq: n=%0d got err=%0d k=%0d nd=%0d want 0 %0d 1",
                         it, n, e, dk, nd, nc + 1);
            else npass++;
            ntot++;
            if (result !== exp_result(nc) || overflow !== fib_ovf(nc))
                $display("FAIL rand%0d_res: n=%0d got %0d/%b want %0d/%b",
                         it, n, result, overflow, exp_result(nc), fib_ovf(nc));
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_fib10();
        test_small();
        test_clamp();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Sequencer FSM that owns the register bank's write port and both read ports.
- On a start pulse, fills consecutive bank registers with the Fibonacci series: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- Each new term is formed from the two previous terms, read back from the bank combinationally, one term per cycle.
- Sits between the top-level control and the register bank.

Parameters:
DATA_W, 32, data width of bank registers and adder
ADDR_W, 5, bank address width (2**ADDR_W registers)
BASE_REG, 1, first bank register written (F(0) stored here); must be >= 1

Ports:
clk  input  1  clock, rising edge
arst_n  input  1  asynchronous active-low reset
start  input  1  1-cycle request; sampled only in IDLE
n_terms  input  6  number of terms to generate; latched on accepted start
busy  output  1  high while sequence is being written
done  output  1  1-cycle pulse when the sequence completes
overflow  output  1  sticky; set if any sum carried out of DATA_W during the run
result  output  DATA_W  last term written; held until the next accepted start
rf_write_en  output  1  to bank write_en
rf_write_dir  output  ADDR_W  to bank write_dir
rf_write_data  output  DATA_W  to bank write_data
rf_read_dir1  output  ADDR_W  to bank read_dir1
rf_read_dir2  output  ADDR_W  to bank read_dir2
rf_read_data1  input  DATA_W  from bank read_data1
rf_read_data2  input  DATA_W  from bank read_data2

Behaviour:
- Reset (async, arst_n=0):
  - state=IDLE; busy, done, overflow, rf_write_en = 0; result=0.
  - All rf_* address/data outputs = 0.
  - Applies immediately, including mid-sequence; the partial series already written to the bank is left as is.
- Accepted n_terms: N = min(n_terms, 2**ADDR_W - BASE_REG). Register 0 is never addressed for write.
- Term index idx: 0..N-1, written to bank address BASE_REG+idx.
- States:
  - IDLE:
    - All rf_* outputs 0, busy=0.
    - start=1 → latch N, clear overflow, clear result.
    - Next state: DONE if N=0, else INIT0.
  - INIT0:
    - busy=1; write_en=1, write_dir=BASE_REG, write_data=0; result<=0.
    - Next state: DONE if N=1, else INIT1.
  - INIT1:
    - busy=1; write_en=1, write_dir=BASE_REG+1, write_data=1; result<=1.
    - Next state: DONE if N=2, else CALC with idx=2.
  - CALC:
    - busy=1; read_dir1=BASE_REG+idx-1, read_dir2=BASE_REG+idx-2.
    - write_en=1, write_dir=BASE_REG+idx.
    - write_data = (rf_read_data1 + rf_read_data2) truncated to DATA_W.
    - Carry out of bit DATA_W-1 → overflow<=1 (sticky); the truncated sum is still written.
    - result<=write_data; idx<=idx+1.
    - Next state: DONE when idx=N-1, else stay in CALC.
  - DONE:
    - done=1 for exactly one cycle, busy=0, write_en=0.
    - Next state: IDLE.
- Read/write addresses never coincide in CALC, so the bank's write-address bypass never feeds a read.
- Outside INIT0/INIT1/CALC all rf_* outputs are driven to 0.
- Timing:
  - Start accepted at edge E → done is high in cycle E+N+1.
  - Exactly N bank writes occur, in consecutive cycles E+1..E+N.
- start is ignored while not in IDLE (including during the DONE cycle).
- n_terms changes after acceptance have no effect.
- All outputs are registered or decoded from registered state only. The exception is rf_write_data in CALC, which is combinational from rf_read_data*.

Test Plan:
- Reset then start with n_terms=10 → bank regs 1..10 = 0,1,1,2,3,5,8,13,21,34; result=34; done high exactly 11 cycles after the start edge; overflow=0; reg 0 untouched.
- n_terms=0, 1, 2 in turn → 0, 1, 2 writes respectively; done at E+1, E+2, E+3; result = 0, 0, 1.
- n_terms=40 with BASE_REG=1 → clamps to 31; regs 1..31 written; reg 31 = 832040; result=832040; done at E+32; no write to address 0.
- DATA_W=16, n_terms=26 → reg 25 = 46368; reg 26 = 75025 mod 65536 = 9489; overflow=1 after the final write and held through IDLE; overflow cleared on the next accepted start.
- Pulse start again while busy at idx=5 of an n_terms=10 run → ignored; sequence completes unchanged; exactly one done pulse.
- Assert arst_n=0 mid-CALC (idx=6) → busy, write_en, done drop immediately; state=IDLE; result=0; a subsequent start with n_terms=4 rewrites regs 1..4 = 0,1,1,2.
